// File: rtl/score_if.sv
// Event and display bundle for the score keeper: game events in, score and display state out.
interface score_if;
    logic       start;
    logic       correct;
    logic       wrong;
    logic       show_high;
    logic [9:0] number;
    logic       change_score;
    logic [9:0] score;
    logic [9:0] high_score;
    logic       game_over;
    logic       new_high;

    modport master (
        output start, correct, wrong, show_high,
        input  number, change_score, score, high_score, game_over, new_high
    );

    modport slave (
        input  start, correct, wrong, show_high,
        output number, change_score, score, high_score, game_over, new_high
    );
endinterface

// File: rtl/score_keeper.sv
// Game score keeper: IDLE/PLAY/OVER game FSM with streak-weighted scoring,
// a saturating score, a high-score record and a registered 3-digit display feed.
module score_keeper (
    input  logic clock,
    input  logic reset_n,
    score_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam logic [9:0] SCORE_MAX  = 10'd999;
    localparam logic [2:0] STREAK_MAX = 3'd7;

    state_t     state_q, state_d;
    logic [9:0] score_q, score_d;
    logic [9:0] high_q, high_d;
    logic [2:0] streak_q, streak_d;
    logic       new_high_q, new_high_d;
    logic [9:0] number_q;
    logic       change_q;
    logic       init_q;
    logic [9:0] disp_sel;

    // Points awarded for a correct round, from the streak held before this round.
    function automatic logic [1:0] points(input logic [2:0] streak);
        logic [1:0] p;
        if (streak <= 3'd2)      p = 2'd1;
        else if (streak <= 3'd5) p = 2'd2;
        else                     p = 2'd3;
        return p;
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [1:0] p);
        logic [10:0] sum;
        sum = {1'b0, a} + {9'b0, p};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            score_q    <= '0;
            high_q     <= '0;
            streak_q   <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            streak_q   <= streak_d;
            new_high_q <= new_high_d;
        end
    end

    // Event priority is start > wrong > correct in every state.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        streak_d   = streak_q;
        new_high_d = new_high_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    streak_d   = '0;
                    new_high_d = 1'b0;
                end
            end
            PLAY: begin
                if (bus.start) begin
                    score_d    = '0;
                    streak_d   = '0;
                    new_high_d = 1'b0;
                end else if (bus.wrong) begin
                    state_d = OVER;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                    end
                end else if (bus.correct) begin
                    score_d  = sat_add(score_q, points(streak_q));
                    streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign disp_sel = bus.show_high ? high_q : score_q;

    // init_q forces one strobe right after reset so the display gets initialised to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            number_q <= '0;
            change_q <= 1'b0;
            init_q   <= 1'b1;
        end else begin
            number_q <= disp_sel;
            change_q <= init_q || (disp_sel != number_q);
            init_q   <= 1'b0;
        end
    end

    assign bus.number       = number_q;
    assign bus.change_score = change_q;
    assign bus.score        = score_q;
    assign bus.high_score   = high_q;
    assign bus.game_over    = (state_q == OVER);
    assign bus.new_high     = new_high_q;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL expose ports as listed:
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a new game
- correct  input  1  one-cycle pulse; player completed a round
- wrong  input  1  one-cycle pulse; player mistake or timeout
- show_high  input  1  level; 1 selects high score for display, 0 selects current score
- number  output  10  value for the 3-digit display, 0..999
- change_score  output  1  one-cycle strobe; number holds a new value
- score  output  10  current game score
- high_score  output  10  best score since reset
- game_over  output  1  high while in OVER state
- new_high  output  1  high when the last finished game set a new high score
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 SHALL implement FSM states IDLE, PLAY, OVER.
REQ-004 IDLE: start -> PLAY; correct/wrong ignored.
REQ-005 PLAY: wrong -> OVER; correct -> stay PLAY and add points; start -> restart (score, streak, new_high cleared, stay PLAY).
REQ-006 OVER: start -> PLAY with score, streak, new_high cleared; correct/wrong ignored.
REQ-007 Simultaneous events SHALL resolve with priority start > wrong > correct.
REQ-008 SHALL keep a 3-bit streak of consecutive correct pulses, saturating at 7, cleared on start.
REQ-009 Points per correct SHALL be based on the streak value before increment: 1 if streak 0..2, 2 if 3..5, 3 if 6..7.
REQ-010 score SHALL saturate at 999; score + points > 999 yields 999, with no wrap.
REQ-011 On the PLAY->OVER transition: if score > high_score, high_score <= score and new_high <= 1; else both unchanged and new_high <= 0; equality SHALL NOT count as new high.
REQ-012 score, high_score, streak, state SHALL update on the same edge that samples the event.
REQ-013 number SHALL be a register loaded with (show_high ? high_score : score) one edge after the source changes (latency 1 cycle from score update, 2 from event).
REQ-014 change_score SHALL be high for exactly one cycle, in the same cycle number first shows a different value; no strobe when the loaded value equals the previous number.
REQ-015 Toggling show_high SHALL produce a strobe only if the selected value differs from the current number.
REQ-016 number SHALL be stable throughout any cycle in which change_score is high.
REQ-017 game_over SHALL equal (state == OVER), registered, no glitches.
REQ-018 SHALL pulse change_score once, with number = 0, in the first cycle after reset_n deasserts (display initialisation).

Reset
REQ-019 reset_n low SHALL immediately force: state IDLE, score 0, high_score 0, streak 0, number 0, change_score 0, game_over 0, new_high 0.
REQ-020 reset asserted mid-game SHALL discard score and high_score; no partial update is committed.

Verification
REQ-021 Reset release -> change_score one cycle, number = 0; then start, 3 correct -> score 3, number 3 after 1 further cycle, 3 strobes total.
REQ-022 start, 8 correct -> score 1+1+1+2+2+2+3+3 = 15; streak = 7; wrong -> game_over 1, high_score 15, new_high 1.
REQ-023 Next game: start, 2 correct, wrong -> score 2, high_score 15, new_high 0; show_high 1 -> number 15 with one strobe; show_high 0 -> number 2 with one strobe.
REQ-024 Force score near 999 (long correct run): score 998 plus 3 points -> 999; further correct -> score 999, no change_score.
REQ-025 Same cycle start + wrong while in PLAY -> restart wins, score 0, state PLAY; same cycle correct + wrong -> OVER, score unchanged.
REQ-026 reset_n low mid-PLAY with score 40 -> all outputs 0 asynchronously; after release, strobe with number 0; correct in IDLE -> no change.
